// File: rtl/inv_round_if.sv
// inv_round_if: handshake bundle for the AES inverse round.
//   i_Data/i_Key/i_Last/i_Valid : upstream state, round key, final-round flag, offer
//   o_Ready                     : block can accept a new state
//   o_Data/o_Valid              : round result and its valid flag
//   i_Ready                     : downstream accepts o_Data
// master = producer/consumer side (controller), slave = the round block.
interface inv_round_if;
  logic [127:0] i_Data;
  logic [127:0] i_Key;
  logic         i_Last;
  logic         i_Valid;
  logic         o_Ready;
  logic [127:0] o_Data;
  logic         o_Valid;
  logic         i_Ready;

  modport master (
    output i_Data, i_Key, i_Last, i_Valid, i_Ready,
    input  o_Ready, o_Data, o_Valid
  );

  modport slave (
    input  i_Data, i_Key, i_Last, i_Valid, i_Ready,
    output o_Ready, o_Data, o_Valid
  );
endinterface

// File: rtl/inv_round.sv
// inv_round: iterative AES inverse cipher round.
//   InvShiftRows at accept, InvSubBytes one column per cycle (4 S-box lookups),
//   AddRoundKey then InvMixColumns (skipped when the round is flagged last).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : inv_round_if.slave (state/key/last in, result out, valid/ready both sides)
// Byte k of a 128-bit word is [127-8k -: 8], at row k%4, column k/4.
module inv_round (
  input  logic           clk,
  input  logic           rst_n,
  inv_round_if.slave     bus
);

  typedef enum logic [2:0] {IDLE, SUB0, SUB1, SUB2, SUB3, KEY, DONE} state_t;

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Rows are rotated right by their row number: out[r][c] = in[r][(c-r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
    return o;
  endfunction

  // Constant multiples built from xtime chains: 09=8+1, 0b=8+2+1, 0d=8+4+1, 0e=8+4+2.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] me [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] m9 [4];
    logic [31:0] o;
    o = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      a[i]  = col[31 - 8*i -: 8];
      m2[i] = xtime(a[i]);
      m4[i] = xtime(m2[i]);
      m8[i] = xtime(m4[i]);
      me[i] = m8[i] ^ m4[i] ^ m2[i];
      mb[i] = m8[i] ^ m2[i] ^ a[i];
      md[i] = m8[i] ^ m4[i] ^ a[i];
      m9[i] = m8[i] ^ a[i];
    end
    for (int unsigned r = 0; r < 4; r++)
      o[31 - 8*r -: 8] = me[2'(r)] ^ mb[2'(r + 1)] ^ md[2'(r + 2)] ^ m9[2'(r + 3)];
    return o;
  endfunction

  state_t       state;
  logic [127:0] st_q;
  logic [127:0] key_q;
  logic         last_q;
  logic [127:0] data_q;
  logic         ready_q;
  logic         valid_q;

  logic [31:0]  col_in;
  logic [31:0]  col_sub;
  logic [127:0] st_sub;
  logic [127:0] x_key;

  // One column per SUB state goes through the four shared S-box lookups.
  always_comb begin
    col_in = '0;
    unique case (state)
      SUB0:    col_in = st_q[127:96];
      SUB1:    col_in = st_q[95:64];
      SUB2:    col_in = st_q[63:32];
      SUB3:    col_in = st_q[31:0];
      default: col_in = '0;
    endcase
    col_sub = '0;
    for (int unsigned i = 0; i < 4; i++)
      col_sub[31 - 8*i -: 8] = inv_sbox(col_in[31 - 8*i -: 8]);
    st_sub = st_q;
    unique case (state)
      SUB0:    st_sub[127:96] = col_sub;
      SUB1:    st_sub[95:64]  = col_sub;
      SUB2:    st_sub[63:32]  = col_sub;
      SUB3:    st_sub[31:0]   = col_sub;
      default: st_sub = st_q;
    endcase
    x_key = st_q ^ key_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      st_q    <= '0;
      key_q   <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.i_Valid) begin
          st_q    <= inv_shift_rows(bus.i_Data);
          key_q   <= bus.i_Key;
          last_q  <= bus.i_Last;
          ready_q <= 1'b0;
          state   <= SUB0;
        end
        SUB0: begin st_q <= st_sub; state <= SUB1; end
        SUB1: begin st_q <= st_sub; state <= SUB2; end
        SUB2: begin st_q <= st_sub; state <= SUB3; end
        SUB3: begin st_q <= st_sub; state <= KEY;  end
        KEY: begin
          data_q  <= last_q ? x_key
                            : {inv_mix_col(x_key[127:96]), inv_mix_col(x_key[95:64]),
                               inv_mix_col(x_key[63:32]),  inv_mix_col(x_key[31:0])};
          valid_q <= 1'b1;
          state   <= DONE;
        end
        DONE: if (bus.i_Ready) begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_Ready = ready_q;
  assign bus.o_Valid = valid_q;
  assign bus.o_Data  = data_q;

endmodule
